uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Control FSM for the UART receiver.
- Detects the start-bit falling edge, enables and tracks the shared edge/bit counter, and generates the sample strobe plus the start/data/parity/stop check strobes for the datapath blocks.
- Collects check results and issues a one-cycle data_valid, or error flags, per frame.
- Sits between the synchronized rx line, the counter, and the sampler/deserializer/checker blocks.

Parameters:
- scale_WIDTH, 6, width of prescaler and edge_cnt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; forces IDLE and clears all outputs.
- rx_in  in  1  serial line, already synchronized to clk; idle high.
- PAR_EN  in  1  parity bit present in frame.
- prescaler  in  scale_WIDTH  oversampling ratio; legal values are 8, 16 and 32.
- edge_cnt  in  scale_WIDTH  counter input, counts 1..prescaler.
- bit_cnt  in  4  counter input, 1 = start, 2..9 = data, 10 = parity or stop, 11 = stop.
- strt_glitch  in  1  start checker result; valid the cycle after strt_chk_en.
- par_err  in  1  parity checker result; valid the cycle after par_chk_en.
- stp_err  in  1  stop checker result; valid the cycle after stp_chk_en.
- cnt_en  out  1  enable to edge/bit counter; counter holds at 1/1 while low.
- dat_samp_en  out  1  sampler majority-window enable.
- strt_chk_en  out  1  one-cycle start-check strobe.
- deser_en  out  1  one-cycle shift strobe to deserializer.
- par_chk_en  out  1  one-cycle parity-check strobe.
- stp_chk_en  out  1  one-cycle stop-check strobe.
- data_valid  out  1  registered one-cycle pulse: frame received with no error.
- par_err_o  out  1  registered one-cycle pulse: frame dropped on parity error.
- stp_err_o  out  1  registered one-cycle pulse: frame dropped on stop error.

Behaviour:
- Reset: state = IDLE; cnt_en, all strobes, data_valid, par_err_o and stp_err_o = 0; latched config and error flags cleared. Reset mid-frame aborts with no output pulse.
- Config latch:
  - P = prescaler and PE = PAR_EN are captured on the IDLE->START transition and used for the whole frame.
  - Live inputs are ignored mid-frame.
- Strobes are decoded combinationally from state and edge_cnt, with H = P/2:
  - dat_samp_en = 1 for edge_cnt in {H-1, H, H+1} in START, DATA, PARITY and STOP.
  - Check strobe fires at edge_cnt == H+2, gated by the current state:
    - START: strt_chk_en.
    - DATA: deser_en.
    - PARITY: par_chk_en.
    - STOP: stp_chk_en.
- cnt_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- IDLE:
  - rx_in == 0 and prescaler legal -> START next cycle; edge_cnt = 1 in the first START cycle.
  - Illegal prescaler: remain in IDLE and ignore the line.
- START:
  - At edge_cnt == H+3, sample strt_glitch into a flag.
  - At edge_cnt == P: glitch -> IDLE with no output; else -> DATA.
- DATA: at edge_cnt == P with bit_cnt == 9 -> PARITY if PE, else STOP; otherwise stay in DATA. Eight deser_en pulses per frame, LSB first.
- PARITY: latch par_err at edge_cnt == H+3; at edge_cnt == P -> STOP.
- STOP: latch stp_err at edge_cnt == H+3, then -> DONE the same cycle. Leaving early gives resync margin for back-to-back frames.
- DONE (one cycle, cnt_en = 0 so the counter returns to 1/1):
  - Registered outputs assert on the following cycle.
  - No errors -> data_valid = 1.
  - Otherwise par_err_o and/or stp_err_o = 1, data_valid = 0; both error pulses may be set together.
  - DONE -> IDLE. If rx_in == 0 in that IDLE cycle, START begins immediately.
- Frame length, start-detect cycle to DONE:
  - No parity: 9P + H + 3 cycles.
  - Parity: 10P + H + 3 cycles.
- Illegal state encoding -> IDLE.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, DONE.
  - prescale constants PRESC_8, PRESC_16, PRESC_32.
  - bit index constants BIT_START = 1, BIT_LAST_DATA = 9, BIT_PAR = 10.
- One sub-module, uart_rx_strobe_gen: combinational decode of (P, edge_cnt) into the sample window, check point H+2, result point H+3 and end point P.

Test Plan:
- P = 8, PE = 0, byte 0x A5 (LSB first), valid stop: exactly 8 deser_en pulses at edge_cnt 6; data_valid pulses once; no error pulse; FSM back in IDLE with cnt_en = 0.
- P = 16, PE = 1, byte 0x3C with wrong parity: par_chk_en at edge_cnt 10 in bit 10; par_err_o pulses once; data_valid stays 0.
- P = 8, rx_in low for 3 cycles then high (strt_glitch = 1): FSM returns to IDLE at edge_cnt 8 of bit 1; no deser_en or valid pulse.
- P = 32, PE = 0, stop bit sampled low: stp_err_o pulses; next frame sent back-to-back is received with data_valid.
- Reset asserted mid-DATA (bit 5), P = 8: next cycle state IDLE, cnt_en = 0, all outputs 0; a subsequent clean frame is received correctly.
- prescaler = 12 with the line toggling: cnt_en never asserts and no strobes fire; PAR_EN changed mid-frame does not alter the frame's bit count.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared state encoding, legal oversampling ratios and bit-slot indices
// for the UART receiver control path.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int unsigned PRESC_8  = 8;
   localparam int unsigned PRESC_16 = 16;
   localparam int unsigned PRESC_32 = 32;

   localparam logic [3:0] BIT_START     = 4'd1;
   localparam logic [3:0] BIT_LAST_DATA = 4'd9;
   localparam logic [3:0] BIT_PAR       = 4'd10;

   function automatic logic presc_legal(input int unsigned p);
      return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the receiver control FSM (master) and the
// line/counter/checker side (slave).
interface uart_rx_fsm_if #(
   parameter int scale_WIDTH = 6
);
   logic                   rx_in;
   logic                   PAR_EN;
   logic [scale_WIDTH-1:0] prescaler;
   logic [scale_WIDTH-1:0] edge_cnt;
   logic [3:0]             bit_cnt;
   logic                   strt_glitch;
   logic                   par_err;
   logic                   stp_err;

   logic                   cnt_en;
   logic                   dat_samp_en;
   logic                   strt_chk_en;
   logic                   deser_en;
   logic                   par_chk_en;
   logic                   stp_chk_en;
   logic                   data_valid;
   logic                   par_err_o;
   logic                   stp_err_o;

   modport master (
      input  rx_in, PAR_EN, prescaler, edge_cnt, bit_cnt,
             strt_glitch, par_err, stp_err,
      output cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
             stp_chk_en, data_valid, par_err_o, stp_err_o
   );

   modport slave (
      output rx_in, PAR_EN, prescaler, edge_cnt, bit_cnt,
             strt_glitch, par_err, stp_err,
      input  cnt_en, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
             stp_chk_en, data_valid, par_err_o, stp_err_o
   );
endinterface

// File: rtl/uart_rx_strobe_gen.sv
// Decodes the in-bit edge count against the latched prescaler into the
// majority sample window, check point, result point and bit end point.
module uart_rx_strobe_gen #(
   parameter int scale_WIDTH = 6
) (
   input  logic [scale_WIDTH-1:0] i_presc,
   input  logic [scale_WIDTH-1:0] i_edge_cnt,
   output logic                   o_samp_win,
   output logic                   o_chk_pt,
   output logic                   o_res_pt,
   output logic                   o_end_pt
);
   logic [scale_WIDTH-1:0] w_half;

   assign w_half = i_presc >> 1;

   assign o_samp_win = (i_edge_cnt == w_half - scale_WIDTH'(1)) ||
                       (i_edge_cnt == w_half) ||
                       (i_edge_cnt == w_half + scale_WIDTH'(1));
   assign o_chk_pt   = (i_edge_cnt == w_half + scale_WIDTH'(2));
   assign o_res_pt   = (i_edge_cnt == w_half + scale_WIDTH'(3));
   assign o_end_pt   = (i_edge_cnt == i_presc);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive control: walks start/data/parity/stop slots off the shared
// counter, strobes the datapath checkers and reports one result pulse per frame.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int scale_WIDTH = 6
) (
   input logic          clk,
   input logic          reset,
   uart_rx_fsm_if.master bus
);
   state_t                 r_state;
   state_t                 w_next;
   logic [scale_WIDTH-1:0] r_presc;
   logic                   r_par_en;
   logic                   r_glitch;
   logic                   r_par_err;
   logic                   r_stp_err;
   logic                   r_data_valid;
   logic                   r_par_err_o;
   logic                   r_stp_err_o;

   logic w_presc_ok;
   logic w_samp_win, w_chk_pt, w_res_pt, w_end_pt;
   logic w_cnt_en, w_samp_en, w_strt_chk, w_deser, w_par_chk, w_stp_chk;

   assign w_presc_ok = presc_legal(32'(bus.prescaler));

   uart_rx_strobe_gen #(.scale_WIDTH(scale_WIDTH)) u_strobe (
      .i_presc    (r_presc),
      .i_edge_cnt (bus.edge_cnt),
      .o_samp_win (w_samp_win),
      .o_chk_pt   (w_chk_pt),
      .o_res_pt   (w_res_pt),
      .o_end_pt   (w_end_pt)
   );

   always_comb begin
      w_next     = r_state;
      w_cnt_en   = 1'b0;
      w_strt_chk = 1'b0;
      w_deser    = 1'b0;
      w_par_chk  = 1'b0;
      w_stp_chk  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!bus.rx_in && w_presc_ok) w_next = START;
         end
         START: begin
            w_cnt_en   = 1'b1;
            w_strt_chk = w_chk_pt;
            if (w_end_pt && bus.bit_cnt == BIT_START)
               w_next = r_glitch ? IDLE : DATA;
         end
         DATA: begin
            w_cnt_en = 1'b1;
            w_deser  = w_chk_pt;
            if (w_end_pt && bus.bit_cnt == BIT_LAST_DATA)
               w_next = r_par_en ? PARITY : STOP;
         end
         PARITY: begin
            w_cnt_en  = 1'b1;
            w_par_chk = w_chk_pt;
            if (w_end_pt && bus.bit_cnt == BIT_PAR) w_next = STOP;
         end
         STOP: begin
            w_cnt_en  = 1'b1;
            w_stp_chk = w_chk_pt;
            // Leave as soon as the stop result is in, to regain margin for the next start edge.
            if (w_res_pt) w_next = DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
      w_samp_en = w_cnt_en & w_samp_win;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_presc      <= '0;
         r_par_en     <= 1'b0;
         r_glitch     <= 1'b0;
         r_par_err    <= 1'b0;
         r_stp_err    <= 1'b0;
         r_data_valid <= 1'b0;
         r_par_err_o  <= 1'b0;
         r_stp_err_o  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next == START) begin
            r_presc   <= bus.prescaler;
            r_par_en  <= bus.PAR_EN;
            r_glitch  <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
         end
         if (r_state == START  && w_res_pt) r_glitch  <= bus.strt_glitch;
         if (r_state == PARITY && w_res_pt) r_par_err <= bus.par_err;
         if (r_state == STOP   && w_res_pt) r_stp_err <= bus.stp_err;
         r_data_valid <= (r_state == DONE) && !r_par_err && !r_stp_err;
         r_par_err_o  <= (r_state == DONE) && r_par_err;
         r_stp_err_o  <= (r_state == DONE) && r_stp_err;
      end
   end

   assign bus.cnt_en      = w_cnt_en;
   assign bus.dat_samp_en = w_samp_en;
   assign bus.strt_chk_en = w_strt_chk;
   assign bus.deser_en    = w_deser;
   assign bus.par_chk_en  = w_par_chk;
   assign bus.stp_chk_en  = w_stp_chk;
   assign bus.data_valid  = r_data_valid;
   assign bus.par_err_o   = r_par_err_o;
   assign bus.stp_err_o   = r_stp_err_o;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench: models the edge/bit counter, majority sampler, deserializer
// and start/parity/stop checkers around the FSM and drives framed serial data.
module tb_uart_rx_fsm;
   import uart_rx_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_rx_fsm_if #(.scale_WIDTH(6)) u_if ();
   uart_rx_fsm #(.scale_WIDTH(6)) dut (.clk(clk), .reset(reset), .bus(u_if));

   int n_chk = 0;
   int n_err = 0;

   logic line_q[$];
   logic [7:0] rx_byte = 8'h00;
   int samp_ones = 0;

   int n_en, n_deser, n_ds_off, n_strt_chk, n_par_chk, n_stp_chk;
   int n_valid, n_perr, n_serr, n_strobe;
   int last_edge, last_bit, pc_edge, pc_bit;
   int chk_edge_exp = 6;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      n_en = 0; n_deser = 0; n_ds_off = 0; n_strt_chk = 0; n_par_chk = 0; n_stp_chk = 0;
      n_valid = 0; n_perr = 0; n_serr = 0; n_strobe = 0;
      last_edge = 0; last_bit = 0; pc_edge = 0; pc_bit = 0;
      samp_ones = 0;
   endtask

   task automatic tick();
      logic en, sc, ds, pc, stc, bitv;
      @(negedge clk);
      en  = u_if.cnt_en;
      sc  = u_if.strt_chk_en;
      ds  = u_if.deser_en;
      pc  = u_if.par_chk_en;
      stc = u_if.stp_chk_en;
      if (u_if.dat_samp_en) samp_ones += int'(u_if.rx_in);
      bitv = (samp_ones >= 2);
      if (sc | ds | pc | stc) samp_ones = 0;
      if (en) begin
         n_en++;
         last_edge = int'(u_if.edge_cnt);
         last_bit  = int'(u_if.bit_cnt);
      end
      if (ds) begin
         n_deser++;
         if (int'(u_if.edge_cnt) != chk_edge_exp) n_ds_off++;
      end
      if (sc) n_strt_chk++;
      if (pc) begin
         n_par_chk++;
         pc_edge = int'(u_if.edge_cnt);
         pc_bit  = int'(u_if.bit_cnt);
      end
      if (stc) n_stp_chk++;
      if (u_if.data_valid) n_valid++;
      if (u_if.par_err_o)  n_perr++;
      if (u_if.stp_err_o)  n_serr++;
      if (en | u_if.dat_samp_en | sc | ds | pc | stc) n_strobe++;

      @(posedge clk);
      #1;
      if (sc)  u_if.strt_glitch = bitv;
      if (ds)  rx_byte = {bitv, rx_byte[7:1]};
      if (pc)  u_if.par_err = (bitv != ^rx_byte);
      if (stc) u_if.stp_err = !bitv;
      if (!en) begin
         u_if.edge_cnt = 6'd1;
         u_if.bit_cnt  = 4'd1;
      end else if (u_if.edge_cnt == u_if.prescaler) begin
         u_if.edge_cnt = 6'd1;
         u_if.bit_cnt  = u_if.bit_cnt + 4'd1;
      end else begin
         u_if.edge_cnt = u_if.edge_cnt + 6'd1;
      end
      if (line_q.size() > 0) u_if.rx_in = line_q.pop_front();
      else                   u_if.rx_in = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_bits(input logic v, input int n);
      for (int i = 0; i < n; i++) line_q.push_back(v);
   endtask

   // Short-low stop keeps the line high once the FSM is back in IDLE.
   task automatic send_frame(input logic [7:0] b, input bit with_par, input logic par_bit,
                             input bit stop_ok, input int p);
      push_bits(1'b0, p);
      for (int i = 0; i < 8; i++) push_bits(b[i], p);
      if (with_par) push_bits(par_bit, p);
      if (stop_ok) push_bits(1'b1, p);
      else begin
         push_bits(1'b0, p / 2 + 2);
         push_bits(1'b1, p - p / 2 - 2);
      end
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_state"}, 32'(dut.r_state), 32'(IDLE));
      check_val({tag, "_cnt_en"}, 32'(u_if.cnt_en), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      u_if.rx_in = 1'b1; u_if.PAR_EN = 1'b0; u_if.prescaler = 6'd8;
      u_if.edge_cnt = 6'd1; u_if.bit_cnt = 4'd1;
      u_if.strt_glitch = 1'b0; u_if.par_err = 1'b0; u_if.stp_err = 1'b0;
      clear_mon();
      run(3);
      check_idle("rst");
      check_val("rst_valid", 32'(u_if.data_valid), 32'd0);
      check_val("rst_errs", 32'({u_if.par_err_o, u_if.stp_err_o}), 32'd0);
      check_val("rst_strobes", 32'({u_if.dat_samp_en, u_if.strt_chk_en, u_if.deser_en,
                                    u_if.par_chk_en, u_if.stp_chk_en}), 32'd0);
      reset = 1'b0;
      run(3);

      // P=8, no parity, 0xA5
      clear_mon(); chk_edge_exp = 6;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
      run(100);
      check_val("t1_deser_cnt", n_deser, 8);
      check_val("t1_deser_edge", n_ds_off, 0);
      check_val("t1_byte", 32'(rx_byte), 32'hA5);
      check_val("t1_valid", n_valid, 1);
      check_val("t1_errs", n_perr + n_serr, 0);
      check_val("t1_len", n_en, 79);
      check_idle("t1");

      // P=16, parity on, 0x3C with odd (wrong) parity bit
      u_if.prescaler = 6'd16; u_if.PAR_EN = 1'b1;
      clear_mon(); chk_edge_exp = 10;
      send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
      run(200);
      check_val("t2_par_chk_cnt", n_par_chk, 1);
      check_val("t2_par_chk_edge", pc_edge, 10);
      check_val("t2_par_chk_bit", pc_bit, 10);
      check_val("t2_par_err", n_perr, 1);
      check_val("t2_stp_err", n_serr, 0);
      check_val("t2_valid", n_valid, 0);
      check_val("t2_len", n_en, 171);
      check_val("t2_byte", 32'(rx_byte), 32'h3C);

      // P=8 start glitch: 3 low cycles
      u_if.prescaler = 6'd8; u_if.PAR_EN = 1'b0;
      run(5);
      clear_mon(); chk_edge_exp = 6;
      push_bits(1'b0, 3);
      run(40);
      check_val("t3_strt_chk", n_strt_chk, 1);
      check_val("t3_deser", n_deser, 0);
      check_val("t3_valid", n_valid + n_perr + n_serr, 0);
      check_val("t3_len", n_en, 8);
      check_val("t3_exit_edge", last_edge, 8);
      check_val("t3_exit_bit", last_bit, 1);
      check_idle("t3");

      // P=32: bad stop then back-to-back good frame
      u_if.prescaler = 6'd32;
      clear_mon(); chk_edge_exp = 18;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 32);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 32);
      run(680);
      check_val("t4_stp_err", n_serr, 1);
      check_val("t4_valid", n_valid, 1);
      check_val("t4_par_err", n_perr, 0);
      check_val("t4_deser", n_deser, 16);
      check_val("t4_deser_edge", n_ds_off, 0);
      check_val("t4_byte", 32'(rx_byte), 32'hC3);
      check_val("t4_len", n_en, 614);

      // P=8 reset in the middle of data bit 5
      u_if.prescaler = 6'd8;
      run(5);
      clear_mon(); chk_edge_exp = 6;
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, 8);
      for (int i = 0; i < 200; i++) begin
         if (u_if.cnt_en && u_if.bit_cnt == 4'd5) break;
         tick();
      end
      check_val("t5_reached_bit5", 32'(u_if.bit_cnt), 32'd5);
      reset = 1'b1;
      line_q.delete();
      u_if.rx_in = 1'b1;
      tick();
      check_idle("t5_abort");
      check_val("t5_abort_outs", 32'({u_if.dat_samp_en, u_if.strt_chk_en, u_if.deser_en,
                                      u_if.par_chk_en, u_if.stp_chk_en, u_if.data_valid,
                                      u_if.par_err_o, u_if.stp_err_o}), 32'd0);
      reset = 1'b0;
      run(20);
      check_val("t5_no_pulse", n_valid + n_perr + n_serr, 0);
      clear_mon();
      send_frame(8'h69, 1'b0, 1'b0, 1'b1, 8);
      run(100);
      check_val("t5_byte", 32'(rx_byte), 32'h69);
      check_val("t5_valid", n_valid, 1);
      check_val("t5_deser", n_deser, 8);

      // Illegal prescaler: line toggling is ignored
      u_if.prescaler = 6'd12;
      clear_mon();
      for (int i = 0; i < 10; i++) begin
         push_bits(1'b0, 1); push_bits(1'b1, 1); push_bits(1'b0, 2);
         push_bits(1'b1, 2); push_bits(1'b0, 1);
      end
      run(80);
      check_val("t6_no_cnt_en", n_en, 0);
      check_val("t6_no_strobe", n_strobe, 0);
      check_val("t6_state", 32'(dut.r_state), 32'(IDLE));

      // PAR_EN raised mid-frame must not add a parity slot
      u_if.prescaler = 6'd8; u_if.PAR_EN = 1'b0;
      run(5);
      clear_mon(); chk_edge_exp = 6;
      send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 8);
      for (int i = 0; i < 200; i++) begin
         if (u_if.cnt_en && u_if.bit_cnt == 4'd3) break;
         tick();
      end
      u_if.PAR_EN = 1'b1;
      run(100);
      u_if.PAR_EN = 1'b0;
      check_val("t6_par_chk", n_par_chk, 0);
      check_val("t6_len", n_en, 79);
      check_val("t6_valid", n_valid, 1);
      check_val("t6_byte", 32'(rx_byte), 32'h0F);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
